i2c_gpio_expander_n: RTL and testbench

- Next-generation I2C slave port expander: fully synchronous, oversampled on the system clock, with N byte-wide GPIO ports behind a register pointer.
- Replaces sclk/sda-edge-clocked logic with a single-clock FSM.
- Adds multi-byte transfers, pointer auto-increment, repeated-START support, input snapshots and an optional change interrupt.
- Sits between the board I2C pins (via external open-drain pad) and the GPIO pins.

---
 rtl/i2c_gpio_expander_n.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_gpio_expander_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_gpio_expander_n.sv
// I2C slave GPIO port expander, oversampled on clk, with N byte-wide ports behind a register pointer.
// Optional change interrupt on irq_n is built when I2C_GPIO_IRQ_EN is defined.
`timescale 1ns/1ps
module i2c_gpio_expander_n #(
    parameter logic [6:0] SLAVE_ADDR = 7'h20,
    parameter int         N_PORTS    = 2,
    parameter int         FILTER_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_oe,
    input  logic [8*N_PORTS-1:0]   gpio_in,
    output logic [8*N_PORTS-1:0]   gpio_out
`ifdef I2C_GPIO_IRQ_EN
    ,
    output logic                   irq_n
`endif
);

    localparam int R     = 2 * N_PORTS;
    localparam int PTR_W = $clog2(R);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic                  scl_p0, scl_p1, sda_p0, sda_p1;
    logic [FILTER_LEN-1:0] scl_sh, sda_sh;
    logic                  scl_f, sda_f, scl_d, sda_d;
    logic [8*N_PORTS-1:0]  gpio_p0, gpio_p1;
    logic                  scl_rise, scl_fall, start_det, stop_det;

    state_t                state;
    logic [2:0]            bit_cnt;
    logic [6:0]            shreg;
    logic                  rw;
    logic                  ack_pend;
    logic [PTR_W-1:0]      ptr;
    logic [8*N_PORTS-1:0]  snap;
    logic                  snap_take;
    logic [7:0]            byte_in;
    logic [7:0]            cur_byte;
    logic [7:0]            first_byte;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(R - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [7:0] reg_byte(input logic [PTR_W-1:0]     p,
                                            input logic [8*N_PORTS-1:0] outs,
                                            input logic [8*N_PORTS-1:0] ins);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < N_PORTS; k++) begin
            if (p == PTR_W'(k))
                r = outs[8*k +: 8];
            if (p == PTR_W'(k + N_PORTS))
                r = ins[8*k +: 8];
        end
        return r;
    endfunction

    // Synchronise and glitch-filter the bus lines; the filtered level moves only on unanimous samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            scl_sh <= '1;
            sda_sh <= '1;
            scl_f  <= 1'b1;
            sda_f  <= 1'b1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
            gpio_p0 <= '0;
            gpio_p1 <= '0;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            scl_sh <= {scl_sh[FILTER_LEN-2:0], scl_p1};
            sda_sh <= {sda_sh[FILTER_LEN-2:0], sda_p1};
            if (&scl_sh)
                scl_f <= 1'b1;
            else if (~|scl_sh)
                scl_f <= 1'b0;
            if (&sda_sh)
                sda_f <= 1'b1;
            else if (~|sda_sh)
                sda_f <= 1'b0;
            scl_d  <= scl_f;
            sda_d  <= sda_f;
            gpio_p0 <= gpio_in;
            gpio_p1 <= gpio_p0;
        end
    end

    // Bus event strobes, one clk wide
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    assign byte_in    = {shreg, sda_f};
    assign cur_byte   = reg_byte(ptr, gpio_out, snap);
    assign first_byte = reg_byte(ptr, gpio_out, gpio_p1);

    // Snapshot at the end of a read-address ack and at every master ack of a read byte
    assign snap_take = !start_det && !stop_det &&
                       (((state == ADDR_ACK) && scl_fall && !ack_pend && rw) ||
                        ((state == RDATA_ACK) && scl_rise && !sda_f));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            snap <= '0;
        else if (snap_take)
            snap <= gpio_p1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd7;
            shreg    <= '0;
            rw       <= 1'b0;
            ack_pend <= 1'b0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            gpio_out <= '0;
        end else if (start_det) begin
            state    <= ADDR;
            bit_cnt  <= 3'd7;
            ack_pend <= 1'b0;
            sda_oe   <= 1'b0;
        end else if (stop_det) begin
            state    <= IDLE;
            bit_cnt  <= 3'd7;
            ack_pend <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            rw <= sda_f;
                            if (shreg == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                ack_pend <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    // First fall drives the ack bit, the second fall ends it
                    if (scl_fall) begin
                        if (ack_pend) begin
                            sda_oe   <= 1'b1;
                            ack_pend <= 1'b0;
                        end else begin
                            bit_cnt <= 3'd7;
                            if (rw) begin
                                state  <= RDATA;
                                sda_oe <= ~first_byte[7];
                            end else begin
                                state  <= PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            if (byte_in < 8'(R)) begin
                                ptr      <= byte_in[PTR_W-1:0];
                                state    <= PTR_ACK;
                                ack_pend <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg   <= byte_in[6:0];
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            for (int k = 0; k < N_PORTS; k++) begin
                                if (ptr == PTR_W'(k))
                                    gpio_out[8*k +: 8] <= byte_in;
                            end
                            ptr      <= ptr_next(ptr);
                            state    <= WDATA_ACK;
                            ack_pend <= 1'b1;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (ack_pend) begin
                            sda_oe   <= 1'b1;
                            ack_pend <= 1'b0;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0)
                            state <= RDATA_ACK;
                    end else if (scl_fall) begin
                        sda_oe <= ~cur_byte[bit_cnt];
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe <= 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_f) begin
                            ptr     <= ptr_next(ptr);
                            bit_cnt <= 3'd7;
                            state   <= RDATA;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                IDLE, IGNORE: begin
                    sda_oe <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    sda_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef I2C_GPIO_IRQ_EN
    // A snapshot clears the request for one clk; a lingering difference re-raises it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_n <= 1'b1;
        else if (snap_take)
            irq_n <= 1'b1;
        else
            irq_n <= ~(|(gpio_p1 ^ snap));
    end
`endif

endmodule

// File: tb/tb_i2c_gpio_expander_n.sv
// Directed bench for i2c_gpio_expander_n: bit-banged I2C master against the default two-port build.
`timescale 1ns/1ps
module tb_i2c_gpio_expander_n;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [15:0] gpio_in = 16'h0000;
    logic        sda_oe;
    logic [15:0] gpio_out;
    logic        sda_line;
`ifdef I2C_GPIO_IRQ_EN
    logic        irq_n;
`endif

    int total = 0;
    int bad = 0;
    int oe_cnt = 0;
    int oe_mark;
    logic       ack;
    logic [7:0] rbyte;
    logic       rbit;

    assign sda_line = m_sda & ~sda_oe;

    i2c_gpio_expander_n #(
        .SLAVE_ADDR (7'h20),
        .N_PORTS    (2),
        .FILTER_LEN (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (m_scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
`ifdef I2C_GPIO_IRQ_EN
        ,
        .irq_n    (irq_n)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sda_oe) oe_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wclk(5);
        m_scl = 1'b1; wclk(5);
        m_sda = 1'b0; wclk(10);
        m_scl = 1'b0; wclk(5);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wclk(5);
        m_scl = 1'b1; wclk(10);
        m_sda = 1'b1; wclk(10);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wclk(5);
        m_scl = 1'b1; wclk(10);
        m_scl = 1'b0; wclk(5);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wclk(5);
        m_scl = 1'b1; wclk(5);
        b = sda_line; wclk(5);
        m_scl = 1'b0; wclk(5);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(master_ack);
    endtask

    initial begin
        wclk(3);
        chk("reset_sda_oe", 32'(sda_oe), 32'h0);
        chk("reset_gpio_out", 32'(gpio_out), 32'h0);
        chk("reset_ptr", 32'(dut.ptr), 32'h0);
`ifdef I2C_GPIO_IRQ_EN
        chk("reset_irq_n", 32'(irq_n), 32'h1);
`endif
        reset_n = 1'b1;
        wclk(5);

        // Write burst
        i2c_start();
        send_byte(8'h40, ack); chk("wr_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h00, ack); chk("wr_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'hA5, ack); chk("wr_d0_ack", 32'(ack), 32'h0);
        send_byte(8'h3C, ack); chk("wr_d1_ack", 32'(ack), 32'h0);
        i2c_stop();
        chk("wr_gpio_out", 32'(gpio_out), 32'h3CA5);
        chk("wr_ptr", 32'(dut.ptr), 32'h2);

        // Combined read with repeated START and pointer wrap
        gpio_in = 16'h1281;
        i2c_start();
        send_byte(8'h40, ack); chk("cr_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h02, ack); chk("cr_ptr_ack", 32'(ack), 32'h0);
        i2c_start();
        send_byte(8'h41, ack); chk("cr_raddr_ack", 32'(ack), 32'h0);
        recv_byte(1'b0, rbyte); chk("cr_byte0", 32'(rbyte), 32'h81);
        recv_byte(1'b0, rbyte); chk("cr_byte1", 32'(rbyte), 32'h12);
        recv_byte(1'b1, rbyte); chk("cr_byte2", 32'(rbyte), 32'hA5);
        i2c_stop();
        chk("cr_ptr_wrap", 32'(dut.ptr), 32'h0);

        // Wrong address is ignored entirely
        oe_mark = oe_cnt;
        i2c_start();
        send_byte(8'h44, ack); chk("wa_addr_nack", 32'(ack), 32'h1);
        send_byte(8'hFF, ack); chk("wa_data_nack", 32'(ack), 32'h1);
        chk("wa_oe_never", 32'(oe_cnt - oe_mark), 32'h0);
        i2c_stop();
        chk("wa_gpio_out", 32'(gpio_out), 32'h3CA5);

        // Out-of-range pointer, then a write to an input index
        i2c_start();
        send_byte(8'h40, ack); chk("op_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h07, ack); chk("op_ptr_nack", 32'(ack), 32'h1);
        i2c_stop();
        chk("op_ptr_kept", 32'(dut.ptr), 32'h0);
        i2c_start();
        send_byte(8'h40, ack); chk("in_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h02, ack); chk("in_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'h55, ack); chk("in_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        chk("in_gpio_out", 32'(gpio_out), 32'h3CA5);
        chk("in_ptr_inc", 32'(dut.ptr), 32'h3);

        // STOP mid-byte aborts the write
        i2c_start();
        send_byte(8'h40, ack); chk("ab_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h00, ack); chk("ab_ptr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        chk("ab_gpio_out", 32'(gpio_out), 32'h3CA5);
        chk("ab_ptr", 32'(dut.ptr), 32'h0);

        // Reset in the middle of a read bit where the slave drives low
        i2c_start();
        send_byte(8'h41, ack); chk("rs_addr_ack", 32'(ack), 32'h0);
        read_bit(rbit); chk("rs_bit7", 32'(rbit), 32'h1);
        wclk(4);
        chk("rs_oe_driving", 32'(sda_oe), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rs_oe_released", 32'(sda_oe), 32'h0);
        chk("rs_gpio_out", 32'(gpio_out), 32'h0);
        chk("rs_ptr", 32'(dut.ptr), 32'h0);
        wclk(3);
        reset_n = 1'b1;
        wclk(10);
        oe_mark = oe_cnt;
        send_byte(8'h40, ack); chk("rs_idle_nack", 32'(ack), 32'h1);
        chk("rs_idle_oe", 32'(oe_cnt - oe_mark), 32'h0);
        i2c_stop();

        i2c_start();
        send_byte(8'h40, ack); chk("pr_addr_ack", 32'(ack), 32'h0);
        send_byte(8'h01, ack); chk("pr_ptr_ack", 32'(ack), 32'h0);
        send_byte(8'h77, ack); chk("pr_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        chk("pr_gpio_out", 32'(gpio_out), 32'h7700);

`ifdef I2C_GPIO_IRQ_EN
        chk("irq_after_reset", 32'(irq_n), 32'h0);
        i2c_start();
        send_byte(8'h41, ack); chk("iq_addr_ack", 32'(ack), 32'h0);
        wclk(4);
        chk("iq_cleared", 32'(irq_n), 32'h1);
        recv_byte(1'b1, rbyte); chk("iq_byte", 32'(rbyte), 32'h81);
        i2c_stop();
        chk("iq_quiet", 32'(irq_n), 32'h1);
        gpio_in = 16'h1280;
        wclk(4);
        chk("iq_change", 32'(irq_n), 32'h0);
        i2c_start();
        send_byte(8'h41, ack); chk("iq_addr2_ack", 32'(ack), 32'h0);
        wclk(4);
        chk("iq_cleared2", 32'(irq_n), 32'h1);
        recv_byte(1'b1, rbyte); chk("iq_byte2", 32'(rbyte), 32'h80);
        i2c_stop();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
